spm_serial_host: RTL and testbench

SPM_SERIAL_HOST -- requirements
Module: spm_serial_host

---
 rtl/spm_serial_host_pkg.sv | 21 ++
 rtl/spm_serial_host_if.sv | 25 ++
 rtl/spm_shift_collect.sv | 20 ++
 rtl/spm_serial_host.sv | 109 ++++++++++
 tb/tb_spm_serial_host.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spm_serial_host_pkg.sv
// Shared types and defaults for the serial-parallel multiplier host.
// The FSM state encoding and the default build constants live here.
package spm_pkg;

   localparam int SPM_WIDTH = 32;
   localparam int SPM_P_LAT = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_SHIFT,
      S_FLUSH,
      S_DONE
   } spm_state_e;

   // Counter must reach 2*w+p (the DONE value) without wrapping.
   function automatic int cnt_w(int w, int p);
      return $clog2(2*w + p + 1);
   endfunction

endpackage

// File: rtl/spm_serial_host_if.sv
// Bundle of operand/product handshakes and the serial link to the spm.
// slave is the host side; master is whoever drives operands and models the spm.
interface spm_serial_host_if #(parameter int WIDTH = 32);

   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_y;
   logic                 spm_rst;
   logic                 spm_y;
   logic                 spm_p;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out_p;

   modport slave (
      input  in_valid, in_y, spm_p, out_ready,
      output in_ready, spm_rst, spm_y, out_valid, out_p
   );

   modport master (
      output in_valid, in_y, spm_p, out_ready,
      input  in_ready, spm_rst, spm_y, out_valid, out_p
   );

endinterface

// File: rtl/spm_shift_collect.sv
// Serial-in/parallel-out product register; each bit enters at the MSB so the
// first bit collected ends up at q[0].
module spm_shift_collect #(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   input  logic         d,
   output logic [N-1:0] q
);

   always_ff @(posedge clk) begin
      if (clr)
         q <= '0;
      else if (en)
         q <= {d, q[N-1:1]};
   end

endmodule

// File: rtl/spm_serial_host.sv
// Host for a serial-parallel multiplier: serializes a signed y operand LSB
// first and collects the 2*WIDTH-bit product from the spm's serial output.
module spm_serial_host
   import spm_pkg::*;
#(
   parameter int WIDTH = SPM_WIDTH,
   parameter int P_LAT = SPM_P_LAT
) (
   input  logic            clk,
   input  logic            rst,
   spm_serial_host_if.slave bus
);

   localparam int PW = 2*WIDTH;
   localparam int CW = cnt_w(WIDTH, P_LAT);

   localparam logic [CW-1:0] SHIFT_LAST = CW'(PW - 1);
   localparam logic [CW-1:0] FLUSH_LAST = CW'(PW + P_LAT - 1);
   localparam logic [CW-1:0] CNT_P      = CW'(P_LAT);

   spm_state_e      state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [PW-1:0]   ysr;
   logic [PW-1:0]   prod;
   logic            sample;
   logic            clr;

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (bus.in_valid)         state_nxt = S_CLEAR;
         S_CLEAR:                           state_nxt = S_SHIFT;
         S_SHIFT: if (cnt == SHIFT_LAST)    state_nxt = S_FLUSH;
         S_FLUSH: if (cnt == FLUSH_LAST)    state_nxt = S_DONE;
         S_DONE:  if (bus.out_ready)        state_nxt = S_IDLE;
         default:                           state_nxt = S_IDLE;
      endcase
   end

   // Outputs are forced to their reset values for the whole time rst is high,
   // not only from the first clock edge that samples it.
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.spm_rst   = 1'b0;
      bus.spm_y     = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_p     = rst ? '0 : prod;
      sample        = 1'b0;
      clr           = 1'b0;
      if (rst) begin
         bus.spm_rst = 1'b1;
         clr         = 1'b1;
      end else begin
         unique case (state)
            S_IDLE:  bus.in_ready = 1'b1;
            S_CLEAR: begin
               bus.spm_rst = 1'b1;
               clr         = 1'b1;
            end
            S_SHIFT: begin
               bus.spm_y = ysr[0];
               sample    = (cnt >= CNT_P);
            end
            S_FLUSH: begin
               bus.spm_y = ysr[0];
               sample    = (cnt >= CNT_P);
            end
            S_DONE:  bus.out_valid = 1'b1;
            default: ;
         endcase
      end
   end

   // Arithmetic shift: once y is exhausted ysr[0] holds the sign bit, which is
   // exactly what FLUSH must keep feeding the spm.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         ysr <= '0;
      end else begin
         unique case (state)
            S_IDLE:  if (bus.in_valid) ysr <= {{WIDTH{bus.in_y[WIDTH-1]}}, bus.in_y};
            S_CLEAR: cnt <= '0;
            S_SHIFT: begin
               cnt <= cnt + 1'b1;
               ysr <= {ysr[PW-1], ysr[PW-1:1]};
            end
            S_FLUSH: cnt <= cnt + 1'b1;
            default: ;
         endcase
      end
   end

   spm_shift_collect #(.N(PW)) u_collect (
      .clk (clk),
      .clr (clr),
      .en  (sample),
      .d   (bus.spm_p),
      .q   (prod)
   );

endmodule

// File: tb/tb_spm_serial_host.sv
// Bench for spm_serial_host (WIDTH=8) with P_LAT=1 and P_LAT=3 builds, each
// attached to a behavioural spm that emits product bits with the given delay.
module tb_spm_serial_host;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spm_serial_host_if #(.WIDTH(8)) bus1 ();
   spm_serial_host_if #(.WIDTH(8)) bus3 ();

   spm_serial_host #(.WIDTH(8), .P_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   spm_serial_host #(.WIDTH(8), .P_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

   function automatic logic [15:0] sext(logic [7:0] v);
      return {{8{v[7]}}, v};
   endfunction

   function automatic logic [15:0] ins(logic [15:0] a, int k, logic b);
      logic [15:0] r;
      r = a;
      if (k < 16) r[k] = b;
      return r;
   endfunction

   // Bit k of x*y depends only on y bits 0..k, so the spm output for bit k is
   // bit k of x times the y bits received so far.
   function automatic logic spm_bit(logic [7:0] x, logic [15:0] ya, int k);
      logic [15:0] pr;
      pr = sext(x) * ya;
      return (k < 16) ? pr[k] : 1'b0;
   endfunction

   logic [7:0]  x1 = '0, x3 = '0;
   logic [15:0] ya1 = '0, ya3 = '0;
   logic [3:0]  dl1 = '0, dl3 = '0;
   int          k1 = 0, k3 = 0;

   always @(posedge clk) begin
      if (bus1.spm_rst) begin
         k1 <= 0; ya1 <= '0; dl1 <= '0;
      end else begin
         ya1 <= ins(ya1, k1, bus1.spm_y);
         dl1 <= {dl1[2:0], spm_bit(x1, ins(ya1, k1, bus1.spm_y), k1)};
         k1  <= (k1 < 40) ? k1 + 1 : k1;
      end
   end
   assign bus1.spm_p = dl1[0];

   always @(posedge clk) begin
      if (bus3.spm_rst) begin
         k3 <= 0; ya3 <= '0; dl3 <= '0;
      end else begin
         ya3 <= ins(ya3, k3, bus3.spm_y);
         dl3 <= {dl3[2:0], spm_bit(x3, ins(ya3, k3, bus3.spm_y), k3)};
         k3  <= (k3 < 40) ? k3 + 1 : k3;
      end
   end
   assign bus3.spm_p = dl3[2];

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   task automatic wait_out1(input int lim);
      int n;
      n = 0;
      while (!bus1.out_valid && n < lim) begin @(negedge clk); n++; end
   endtask

   task automatic wait_rdy1(input int lim);
      int n;
      n = 0;
      while (!bus1.in_ready && n < lim) begin @(negedge clk); n++; end
   endtask

   task automatic txn1(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp);
      int h;
      @(negedge clk);
      x1 = x; bus1.in_y = y; bus1.in_valid = 1'b1;
      wait_rdy1(50);
      chk("accept", bus1.in_ready, 1);
      h = cyc + 1;
      @(negedge clk);
      bus1.in_valid = 1'b0;
      wait_out1(100);
      chk("latency", cyc - h, 18);
      chk("product", bus1.out_p, exp);
      bus1.out_ready = 1'b1;
      @(negedge clk);
      bus1.out_ready = 1'b0;
      chk("release", bus1.out_valid, 0);
   endtask

   typedef struct {
      logic [7:0]  x;
      logic [7:0]  y;
      logic [15:0] p;
   } vec_t;

   vec_t        tbl[5];
   logic [7:0]  ra, rb;
   logic [15:0] hold_p;
   int          h, h2, pulses, n;

   initial begin
      tbl[0] = '{8'h03, 8'h05, 16'h000F};
      tbl[1] = '{8'hFF, 8'h02, 16'hFFFE};
      tbl[2] = '{8'h80, 8'h80, 16'h4000};
      tbl[3] = '{8'h02, 8'h09, 16'h0012};
      tbl[4] = '{8'h07, 8'hFD, 16'hFFEB};

      bus1.in_valid = 1'b0; bus1.in_y = '0; bus1.out_ready = 1'b0;
      bus3.in_valid = 1'b0; bus3.in_y = '0; bus3.out_ready = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst in_ready", bus1.in_ready, 0);
      chk("rst spm_rst", bus1.spm_rst, 1);
      chk("rst spm_y", bus1.spm_y, 0);
      chk("rst out_valid", bus1.out_valid, 0);
      chk("rst out_p", bus1.out_p, 0);
      chk("rst out_valid3", bus3.out_valid, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post-rst in_ready", bus1.in_ready, 1);
      chk("idle spm_rst", bus1.spm_rst, 0);

      for (int i = 0; i < 5; i++) txn1(tbl[i].x, tbl[i].y, tbl[i].p);

      for (int i = 0; i < 16; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         txn1(ra, rb, sext(ra) * sext(rb));
      end

      // DONE held with out_ready low; in_valid meanwhile must be ignored
      @(negedge clk);
      x1 = 8'h0C; bus1.in_y = 8'h0A; bus1.in_valid = 1'b1;
      wait_rdy1(50);
      @(negedge clk);
      wait_out1(100);
      chk("hold valid", bus1.out_valid, 1);
      hold_p = bus1.out_p;
      chk("hold product", hold_p, 16'h0078);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold stable valid", bus1.out_valid, 1);
         chk("hold stable p", bus1.out_p, 16'h0078);
         chk("hold in_ready", bus1.in_ready, 0);
      end
      bus1.in_valid = 1'b0;
      bus1.out_ready = 1'b1;
      @(negedge clk);
      bus1.out_ready = 1'b0;
      chk("hold release", bus1.out_valid, 0);

      // back-to-back with in_valid and out_ready both held high
      @(negedge clk);
      x1 = 8'h03; bus1.in_y = 8'h05; bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
      wait_rdy1(50);
      h = cyc + 1;
      @(negedge clk);
      chk("b2b busy in_ready", bus1.in_ready, 0);
      wait_out1(100);
      chk("b2b lat1", cyc - h, 18);
      chk("b2b p1", bus1.out_p, 16'h000F);
      chk("b2b done in_ready", bus1.in_ready, 0);
      x1 = 8'h07; bus1.in_y = 8'hFD;
      @(negedge clk);
      chk("b2b out dropped", bus1.out_valid, 0);
      chk("b2b idle in_ready", bus1.in_ready, 1);
      h2 = cyc + 1;
      @(negedge clk);
      bus1.in_valid = 1'b0;
      chk("b2b accepted", bus1.in_ready, 0);
      wait_out1(100);
      chk("b2b lat2", cyc - h2, 18);
      chk("b2b p2", bus1.out_p, 16'hFFEB);
      @(negedge clk);
      bus1.out_ready = 1'b0;

      // reset in SHIFT cycle 4 abandons the transaction
      @(negedge clk);
      x1 = 8'h11; bus1.in_y = 8'h22; bus1.in_valid = 1'b1;
      wait_rdy1(50);
      h = cyc + 1;
      @(negedge clk);
      bus1.in_valid = 1'b0;
      n = 0;
      while (cyc < h + 5 && n < 50) begin @(negedge clk); n++; end
      chk("mid spm_rst", bus1.spm_rst, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid-rst in_ready", bus1.in_ready, 0);
      chk("mid-rst spm_rst", bus1.spm_rst, 1);
      chk("mid-rst spm_y", bus1.spm_y, 0);
      chk("mid-rst out_p", bus1.out_p, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("mid-rst recover", bus1.in_ready, 1);
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus1.out_valid) pulses++;
         @(negedge clk);
      end
      chk("abandoned pulses", pulses, 0);
      txn1(8'h02, 8'h09, 16'h0012);

      // P_LAT=3 build
      @(negedge clk);
      x3 = 8'hFB; bus3.in_y = 8'hF9; bus3.in_valid = 1'b1;
      n = 0;
      while (!bus3.in_ready && n < 50) begin @(negedge clk); n++; end
      h = cyc + 1;
      @(negedge clk);
      bus3.in_valid = 1'b0;
      n = 0;
      while (!bus3.out_valid && n < 100) begin @(negedge clk); n++; end
      chk("p3 latency", cyc - h, 20);
      chk("p3 product", bus3.out_p, 16'h0023);
      bus3.out_ready = 1'b1;
      @(negedge clk);
      bus3.out_ready = 1'b0;
      chk("p3 release", bus3.out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
